// File: rtl/bus_arb_pkg.sv
// Shared definitions for the two-master bus arbiter: FSM/owner encodings,
// bus widths, reset/open-bus constants and the bus command payload.
package bus_arb_pkg;

   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DATA_W = 8;

   // Arbiter state encoding
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_XFER = 2'd1;
   localparam logic [1:0] ST_ACK  = 2'd2;

   // Bus owner encoding
   localparam logic OWNER_CPU = 1'b0;
   localparam logic OWNER_DMA = 1'b1;

   // Value returned when nothing drives the data bus
   localparam logic [DATA_W-1:0] OPEN_BUS = 8'hFF;

   // Shared-bus drive values while idle or after reset
   localparam logic [ADDR_W-1:0] RESET_ADDR  = 16'h0000;
   localparam logic              RESET_RNW   = 1'b1;
   localparam logic [DATA_W-1:0] RESET_WDATA = 8'h00;

   // Command presented on the shared bus
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic              rnw;
      logic [DATA_W-1:0] wdata;
   } bus_cmd_t;

   // Pack one requester's signals into a bus command
   function automatic bus_cmd_t make_cmd(input logic [ADDR_W-1:0] addr,
                                         input logic              rnw,
                                         input logic [DATA_W-1:0] wdata);
      bus_cmd_t cmd;
      cmd.addr  = addr;
      cmd.rnw   = rnw;
      cmd.wdata = wdata;
      return cmd;
   endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// Cycle counter bounding how long a slow bus access may wait for its ack.
// Armed by start, disarmed by ack; expired flags the last allowed cycle.
module bus_wait_timer
#(
   parameter int unsigned TIMEOUT = 15
)
(
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic ack,
   output logic expired
);

   localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT - 1);

   logic             armed;
   logic [CNT_W-1:0] cnt;

   // Count cycles since start; hold at LAST until the access completes
   always_ff @(posedge clk) begin
      if (rst) begin
         armed <= 1'b0;
         cnt   <= '0;
      end else if (start) begin
         armed <= 1'b1;
         cnt   <= '0;
      end else if (ack) begin
         armed <= 1'b0;
         cnt   <= '0;
      end else if (armed && (cnt != LAST)) begin
         cnt   <= cnt + CNT_W'(1);
      end
   end

   // High during the final permitted cycle of the access
   assign expired = armed && (cnt == LAST);

endmodule

// File: rtl/bus_master_arbiter.sv
// Two-master (CPU/DMA) arbiter for a shared 16-bit address, 8-bit data bus.
// DMA has priority but is limited to DMA_BURST_MAX back-to-back grants while
// the CPU waits. Slow-region accesses wait for i_bus_ack, bounded by a timer.
module bus_master_arbiter
   import bus_arb_pkg::*;
#(
   parameter int unsigned DMA_BURST_MAX = 4,
   parameter int unsigned SLOW_TIMEOUT  = 15
)
(
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_cpu_req,
   input  logic [ADDR_W-1:0] i_cpu_addr,
   input  logic              i_cpu_rnw,
   input  logic [DATA_W-1:0] i_cpu_wdata,
   output logic              o_cpu_ack,
   output logic [DATA_W-1:0] o_cpu_rdata,
   input  logic              i_dma_req,
   input  logic [ADDR_W-1:0] i_dma_addr,
   input  logic              i_dma_rnw,
   input  logic [DATA_W-1:0] i_dma_wdata,
   output logic              o_dma_ack,
   output logic [DATA_W-1:0] o_dma_rdata,
   output logic              o_bus_valid,
   output logic [ADDR_W-1:0] o_bus_addr,
   output logic              o_bus_rnw,
   output logic [DATA_W-1:0] o_bus_wdata,
   input  logic [DATA_W-1:0] i_bus_rdata,
   input  logic              i_bus_slow,
   input  logic              i_bus_ack,
   output logic              o_timeout
);

   localparam int unsigned BURST_W = (DMA_BURST_MAX > 0) ? $clog2(DMA_BURST_MAX + 1) : 1;
   localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(DMA_BURST_MAX);

   logic [1:0]         state_q,      state_d;
   logic               owner_q,      owner_d;
   logic [BURST_W-1:0] burst_q,      burst_d;
   bus_cmd_t           cmd_q,        cmd_d;
   logic               bus_valid_q,  bus_valid_d;
   logic               cpu_ack_q,    cpu_ack_d;
   logic               dma_ack_q,    dma_ack_d;
   logic [DATA_W-1:0]  cpu_rdata_q,  cpu_rdata_d;
   logic [DATA_W-1:0]  dma_rdata_q,  dma_rdata_d;
   logic               timeout_q,    timeout_d;

   logic               grant_c;
   logic               done_c;
   logic               dma_win_c;
   logic [DATA_W-1:0]  rdata_sel_c;
   logic               expired;

   // Bounds the wait of a slow access; restarted on every grant
   bus_wait_timer #(
      .TIMEOUT (SLOW_TIMEOUT)
   ) u_wait_timer (
      .clk     (i_clk),
      .rst     (i_rst),
      .start   (grant_c),
      .ack     (done_c),
      .expired (expired)
   );

   // Next-state and next-output decode
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      burst_d     = burst_q;
      cmd_d       = cmd_q;
      bus_valid_d = bus_valid_q;
      cpu_ack_d   = 1'b0;
      dma_ack_d   = 1'b0;
      cpu_rdata_d = cpu_rdata_q;
      dma_rdata_d = dma_rdata_q;
      timeout_d   = 1'b0;
      grant_c     = 1'b0;
      done_c      = 1'b0;
      dma_win_c   = 1'b0;
      rdata_sel_c = i_bus_rdata;

      case (state_q)
         ST_IDLE: begin
            if (i_cpu_req || i_dma_req) begin
               // DMA wins unless it has used up its burst while the CPU waits
               dma_win_c   = i_dma_req && (!i_cpu_req || (burst_q != BURST_MAX));
               grant_c     = 1'b1;
               bus_valid_d = 1'b1;
               state_d     = ST_XFER;
               if (dma_win_c) begin
                  owner_d = OWNER_DMA;
                  cmd_d   = make_cmd(i_dma_addr, i_dma_rnw, i_dma_wdata);
                  if (i_cpu_req && (burst_q != BURST_MAX)) begin
                     burst_d = burst_q + BURST_W'(1);
                  end
               end else begin
                  owner_d = OWNER_CPU;
                  cmd_d   = make_cmd(i_cpu_addr, i_cpu_rnw, i_cpu_wdata);
                  burst_d = '0;
               end
            end
         end

         ST_XFER: begin
            // Fast targets finish at once; slow ones on ack or expiry
            if (!i_bus_slow || i_bus_ack || expired) begin
               done_c      = 1'b1;
               timeout_d   = i_bus_slow && !i_bus_ack;
               rdata_sel_c = timeout_d ? OPEN_BUS : i_bus_rdata;
               bus_valid_d = 1'b0;
               state_d     = ST_ACK;
               if (owner_q == OWNER_DMA) begin
                  dma_ack_d = 1'b1;
                  if (cmd_q.rnw) begin
                     dma_rdata_d = rdata_sel_c;
                  end
               end else begin
                  cpu_ack_d = 1'b1;
                  if (cmd_q.rnw) begin
                     cpu_rdata_d = rdata_sel_c;
                  end
               end
            end
         end

         ST_ACK: begin
            // Ack pulse is on the outputs; requests are not sampled here
            state_d = ST_IDLE;
         end

         default: begin
            state_d     = ST_IDLE;
            bus_valid_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q     <= ST_IDLE;
         owner_q     <= OWNER_CPU;
         burst_q     <= '0;
         cmd_q       <= make_cmd(RESET_ADDR, RESET_RNW, RESET_WDATA);
         bus_valid_q <= 1'b0;
         cpu_ack_q   <= 1'b0;
         dma_ack_q   <= 1'b0;
         cpu_rdata_q <= OPEN_BUS;
         dma_rdata_q <= OPEN_BUS;
         timeout_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         burst_q     <= burst_d;
         cmd_q       <= cmd_d;
         bus_valid_q <= bus_valid_d;
         cpu_ack_q   <= cpu_ack_d;
         dma_ack_q   <= dma_ack_d;
         cpu_rdata_q <= cpu_rdata_d;
         dma_rdata_q <= dma_rdata_d;
         timeout_q   <= timeout_d;
      end
   end

   assign o_cpu_ack   = cpu_ack_q;
   assign o_cpu_rdata = cpu_rdata_q;
   assign o_dma_ack   = dma_ack_q;
   assign o_dma_rdata = dma_rdata_q;
   assign o_bus_valid = bus_valid_q;
   assign o_bus_addr  = cmd_q.addr;
   assign o_bus_rnw   = cmd_q.rnw;
   assign o_bus_wdata = cmd_q.wdata;
   assign o_timeout   = timeout_q;

endmodule
